// File: rtl/tick_scheduler.sv
// Run-control and period controller for the clock-enable tick.
// Counts a prescaler up to a programmable period and emits a one-cycle tick when it is reached.
module tick_scheduler #(
  parameter int unsigned PW             = 20,
  parameter int unsigned DEFAULT_PERIOD = 10000,
  parameter int unsigned CW             = 16
) (
  input  logic          clk_in,
  input  logic          reset_n,
  input  logic          load,
  input  logic [PW-1:0] period_in,
  input  logic          start,
  input  logic          pause,
  input  logic          step,
  input  logic          clear,
  output logic          tick,
  output logic          running,
  output logic          paused,
  output logic [PW-1:0] period_out,
  output logic [CW-1:0] tick_count,
  output logic          load_err
);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StStep} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] count_q, count_d;
  logic [PW-1:0] period_q, period_d;
  logic [CW-1:0] tick_count_q, tick_count_d;
  logic          load_err_q, load_err_d;

  logic [PW-1:0] count_adv;
  logic          load_ok;

  assign count_adv = (count_q == period_q) ? '0 : count_q + 1'b1;
  // A clear on the same edge opens the period register regardless of state.
  assign load_ok   = load & (clear | (state_q == StIdle) | (state_q == StPause));

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    period_d     = period_q;
    tick_count_d = tick_count_q;
    load_err_d   = load & ~load_ok;

    if (clear) begin
      state_d = StIdle;
      count_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) state_d = StRun;
        end
        StRun: begin
          if (pause) state_d = StPause;
          else       count_d = count_adv;
        end
        StPause: begin
          if (start)     state_d = StRun;
          else if (step) state_d = StStep;
        end
        StStep: begin
          count_d = count_adv;
          state_d = StPause;
        end
        default: state_d = StIdle;
      endcase
    end

    if (load_ok) begin
      period_d = period_in;
      // Keep the held count within the new period so it can still reach it.
      if (!clear && (state_q == StPause) && (count_q > period_in)) count_d = '0;
    end

    if (clear)     tick_count_d = '0;
    else if (tick) tick_count_d = tick_count_q + 1'b1;
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      count_q      <= '0;
      period_q     <= PW'(DEFAULT_PERIOD);
      tick_count_q <= '0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      period_q     <= period_d;
      tick_count_q <= tick_count_d;
      load_err_q   <= load_err_d;
    end
  end

  assign tick       = ((state_q == StRun) || (state_q == StStep)) && (count_q == period_q);
  assign running    = (state_q == StRun);
  assign paused     = (state_q == StPause) || (state_q == StStep);
  assign period_out = period_q;
  assign tick_count = tick_count_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed plus randomized bench for tick_scheduler, checked against a cycle-level reference
// model that follows the run-control rules with plain integer arithmetic.
module tb_tick_scheduler;

  localparam int unsigned PW = 20;
  localparam int unsigned DP = 10000;
  localparam int unsigned CW = 4;

  localparam int MIDLE  = 0;
  localparam int MRUN   = 1;
  localparam int MPAUSE = 2;
  localparam int MSTEP  = 3;

  logic          clk_in = 1'b0;
  logic          reset_n = 1'b1;
  logic          load = 1'b0, start = 1'b0, pause = 1'b0, step = 1'b0, clear = 1'b0;
  logic [PW-1:0] period_in = '0;
  logic          tick, running, paused, load_err;
  logic [PW-1:0] period_out;
  logic [CW-1:0] tick_count;

  tick_scheduler #(
    .PW            (PW),
    .DEFAULT_PERIOD(DP),
    .CW            (CW)
  ) dut (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .load      (load),
    .period_in (period_in),
    .start     (start),
    .pause     (pause),
    .step      (step),
    .clear     (clear),
    .tick      (tick),
    .running   (running),
    .paused    (paused),
    .period_out(period_out),
    .tick_count(tick_count),
    .load_err  (load_err)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  int m_mode, m_cnt, m_per, m_tc, m_lerr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = MIDLE;
    m_cnt  = 0;
    m_per  = DP;
    m_tc   = 0;
    m_lerr = 0;
  endtask

  // Advance the model by one rising edge using the inputs sampled at that edge.
  task automatic model_step();
    int  n_mode, n_cnt, pin;
    bit  acc, tk;
    pin    = int'(period_in);
    tk     = ((m_mode == MRUN) || (m_mode == MSTEP)) && (m_cnt == m_per);
    acc    = load && (clear || m_mode == MIDLE || m_mode == MPAUSE);
    n_mode = m_mode;
    n_cnt  = m_cnt;
    if (clear) begin
      n_mode = MIDLE;
      n_cnt  = 0;
    end else if (m_mode == MIDLE) begin
      if (start) n_mode = MRUN;
    end else if (m_mode == MRUN) begin
      if (pause) n_mode = MPAUSE;
      else       n_cnt = (m_cnt + 1) % (m_per + 1);
    end else if (m_mode == MPAUSE) begin
      if (start)     n_mode = MRUN;
      else if (step) n_mode = MSTEP;
    end else begin
      n_cnt  = (m_cnt + 1) % (m_per + 1);
      n_mode = MPAUSE;
    end
    if (acc) begin
      if (!clear && m_mode == MPAUSE && m_cnt > pin) n_cnt = 0;
      m_per = pin;
    end
    if (clear)   m_tc = 0;
    else if (tk) m_tc = (m_tc + 1) % (1 << CW);
    m_lerr = (load && !acc) ? 1 : 0;
    m_mode = n_mode;
    m_cnt  = n_cnt;
  endtask

  task automatic check_all(input string tag);
    int e_tick;
    e_tick = (((m_mode == MRUN) || (m_mode == MSTEP)) && (m_cnt == m_per)) ? 1 : 0;
    chk({tag, ".tick"}, 32'(tick), 32'(e_tick));
    chk({tag, ".running"}, 32'(running), (m_mode == MRUN) ? 32'd1 : 32'd0);
    chk({tag, ".paused"}, 32'(paused), (m_mode == MPAUSE || m_mode == MSTEP) ? 32'd1 : 32'd0);
    chk({tag, ".period_out"}, 32'(period_out), 32'(m_per));
    chk({tag, ".tick_count"}, 32'(tick_count), 32'(m_tc));
    chk({tag, ".load_err"}, 32'(load_err), 32'(m_lerr));
  endtask

  task automatic cyc(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      model_step();
      #1;
      check_all(tag);
    end
  endtask

  task automatic drop_inputs();
    load  = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    step  = 1'b0;
    clear = 1'b0;
  endtask

  initial begin
    // Reset and defaults
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    model_reset();
    check_all("reset");
    chk("reset.period_default", 32'(period_out), 32'd10000);
    reset_n = 1'b1;
    cyc(2, "idle");

    // Periodic run, P=3
    load = 1'b1; period_in = 3; cyc(1, "load3"); drop_inputs();
    start = 1'b1; cyc(1, "start3"); drop_inputs();
    cyc(3, "run3");
    chk("run3.tick1", 32'(tick), 32'd1);
    cyc(4, "run3");
    chk("run3.tick2", 32'(tick), 32'd1);
    cyc(4, "run3");
    chk("run3.tick3", 32'(tick), 32'd1);
    cyc(1, "run3");
    chk("run3.count3", 32'(tick_count), 32'd3);
    chk("run3.running", 32'(running), 32'd1);

    // Pause / step / resume, P=4
    clear = 1'b1; cyc(1, "clr"); drop_inputs();
    load = 1'b1; period_in = 4; cyc(1, "load4"); drop_inputs();
    start = 1'b1; cyc(1, "start4"); drop_inputs();
    cyc(2, "run4");
    pause = 1'b1; cyc(1, "pause4"); drop_inputs();
    cyc(3, "hold4");
    chk("hold4.notick", 32'(tick), 32'd0);
    step = 1'b1; cyc(1, "step_a"); drop_inputs();
    cyc(1, "step_a2");
    step = 1'b1; cyc(1, "step_b"); drop_inputs();
    cyc(1, "step_b2");
    step = 1'b1; cyc(1, "step_c"); drop_inputs();
    chk("step_c.tick", 32'(tick), 32'd1);
    cyc(1, "step_c2");
    chk("step_c2.count", 32'(tick_count), 32'd1);
    start = 1'b1; cyc(1, "resume"); drop_inputs();
    cyc(4, "resume_run");
    chk("resume.tick", 32'(tick), 32'd1);

    // Load rules
    load = 1'b1; period_in = 2; cyc(1, "load_run"); drop_inputs();
    chk("load_run.err", 32'(load_err), 32'd1);
    chk("load_run.period", 32'(period_out), 32'd4);
    cyc(1, "load_run2");
    chk("load_run2.err", 32'(load_err), 32'd0);
    clear = 1'b1; cyc(1, "clr"); drop_inputs();
    load = 1'b1; period_in = 9; cyc(1, "load9"); drop_inputs();
    start = 1'b1; cyc(1, "start9"); drop_inputs();
    cyc(7, "run9");
    pause = 1'b1; cyc(1, "pause9"); drop_inputs();
    load = 1'b1; period_in = 2; cyc(1, "clamp"); drop_inputs();
    chk("clamp.period", 32'(period_out), 32'd2);
    start = 1'b1; cyc(1, "clamp_run"); drop_inputs();
    cyc(2, "clamp_run2");
    chk("clamp.tick", 32'(tick), 32'd1);

    // Priority and clear
    clear = 1'b1; start = 1'b1; pause = 1'b1; cyc(1, "prio_clr"); drop_inputs();
    chk("prio_clr.running", 32'(running), 32'd0);
    chk("prio_clr.tc", 32'(tick_count), 32'd0);
    start = 1'b1; cyc(1, "prio_start"); drop_inputs();
    cyc(1, "prio_run");
    pause = 1'b1; start = 1'b1; cyc(1, "prio_pause"); drop_inputs();
    chk("prio_pause.paused", 32'(paused), 32'd1);

    // Wrap with P=0
    clear = 1'b1; cyc(1, "clr"); drop_inputs();
    load = 1'b1; period_in = 0; cyc(1, "load0"); drop_inputs();
    start = 1'b1; cyc(1, "start0"); drop_inputs();
    chk("p0.tick", 32'(tick), 32'd1);
    cyc(17, "wrap");
    chk("wrap.tc", 32'(tick_count), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      clear     = ($urandom_range(0, 99) < 3);
      pause     = ($urandom_range(0, 99) < 8);
      start     = ($urandom_range(0, 99) < 10);
      step      = ($urandom_range(0, 99) < 15);
      load      = ($urandom_range(0, 99) < 12);
      period_in = PW'($urandom_range(0, 6));
      cyc(1, "rand");
    end
    drop_inputs();

    // Asynchronous reset mid-cycle
    clear = 1'b1; cyc(1, "clr"); drop_inputs();
    load = 1'b1; period_in = 1; cyc(1, "load1"); drop_inputs();
    start = 1'b1; cyc(1, "start1"); drop_inputs();
    cyc(3, "run1");
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all("areset");
    @(posedge clk_in);
    #1;
    check_all("areset_hold");
    #3 reset_n = 1'b1;
    cyc(2, "post_reset");
    load = 1'b1; period_in = 1; cyc(1, "post_load"); drop_inputs();
    start = 1'b1; cyc(1, "post_start"); drop_inputs();
    cyc(5, "post_run");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
